// File: rtl/irq_arbiter.sv
// Interrupt arbiter: picks one masked pending line, presents it to the core with
// its mcause value, and routes the core's mret back as a one-cycle pulse to that source.
module irq_arbiter #(
    parameter int N_IRQ       = 16,
    parameter int ROUND_ROBIN = 0,
    parameter int CAUSE_BASE  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_IRQ-1:0]         irq_lines_i,
    input  logic [N_IRQ-1:0]         irq_mask_i,
    output logic                     irq_req_o,
    output logic [31:0]              irq_cause_o,
    output logic [$clog2(N_IRQ)-1:0] irq_id_o,
    input  logic                     irq_ret_i,
    output logic [N_IRQ-1:0]         irq_ret_o
);

    localparam int ID_W = $clog2(N_IRQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_d;
    logic [31:0]       cause_d;
    logic [ID_W-1:0]   id_d;
    logic [N_IRQ-1:0]  ret_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_IRQ-1:0]  pending;
    logic [ID_W-1:0]   winner;

    // Scans from the highest candidate down so the preferred candidate is assigned last.
    function automatic logic [ID_W-1:0] pick(input logic [N_IRQ-1:0] pend,
                                             input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] w;
        int              idx;
        w = '0;
        if (ROUND_ROBIN != 0) begin
            for (int off = N_IRQ; off >= 1; off--) begin
                idx = (int'(ptr) + off) % N_IRQ;
                if (pend[ID_W'(idx)]) w = ID_W'(idx);
            end
        end else begin
            for (int i = N_IRQ - 1; i >= 0; i--) begin
                if (pend[ID_W'(i)]) w = ID_W'(i);
            end
        end
        return w;
    endfunction

    assign pending = irq_lines_i & irq_mask_i;
    assign winner  = pick(pending, ptr_q);

    always_comb begin
        state_d = state_q;
        req_d   = irq_req_o;
        cause_d = irq_cause_o;
        id_d    = irq_id_o;
        ret_d   = '0;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    state_d = ACTIVE;
                    req_d   = 1'b1;
                    id_d    = winner;
                    cause_d = {1'b1, 31'(CAUSE_BASE) + 31'(winner)};
                    ptr_d   = winner;
                end
            end
            ACTIVE: begin
                // The request is held regardless of line or mask changes until mret.
                if (irq_ret_i) begin
                    state_d = RETURN;
                    req_d   = 1'b0;
                    ret_d   = N_IRQ'(1) << irq_id_o;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            irq_req_o   <= 1'b0;
            irq_cause_o <= '0;
            irq_id_o    <= '0;
            irq_ret_o   <= '0;
            ptr_q       <= ID_W'(N_IRQ - 1);
        end else begin
            state_q     <= state_d;
            irq_req_o   <= req_d;
            irq_cause_o <= cause_d;
            irq_id_o    <= id_d;
            irq_ret_o   <= ret_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Multi-source interrupt arbiter between level-sensitive peripheral interrupt lines and the core's single interrupt input.
- Peripheral lines include the PS/2 controller's interrupt request (unread scan code), UART, timer, etc.
- Selects one masked pending source, presents it to the core with a RISC-V mcause value, and routes the core's return (mret) back as a one-cycle return pulse to the serviced peripheral only.
- Supports fixed-priority or round-robin selection.

Parameters:
- N_IRQ, 16, number of interrupt sources (2..32).
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after last serviced index.
- CAUSE_BASE, 16, mcause exception code of source 0; source k reports CAUSE_BASE+k.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-low reset.
- irq_lines_i  input  N_IRQ  level interrupt requests from peripherals; bit k = source k.
- irq_mask_i  input  N_IRQ  per-source enable from core CSR; 1 = enabled.
- irq_req_o  output  1  interrupt request to core.
- irq_cause_o  output  32  mcause for current interrupt: bit31 = 1, bits[30:0] = CAUSE_BASE + id.
- irq_id_o  output  $clog2(N_IRQ)  index of source being serviced.
- irq_ret_i  input  1  interrupt return from core (mret executed), single-cycle pulse.
- irq_ret_o  output  N_IRQ  one-hot return pulse to serviced peripheral.

Behaviour:
- All outputs registered. Reset (rst_i low, async) values: state IDLE, irq_req_o=0, irq_cause_o=0, irq_id_o=0, irq_ret_o=0, round-robin pointer=N_IRQ-1 (first search starts at index 0).
- FSM states: IDLE, ACTIVE, RETURN.
- IDLE, pending = irq_lines_i & irq_mask_i:
  - pending != 0 at a clock edge: latch winner into id, irq_cause_o={1'b1, CAUSE_BASE+winner}; enter ACTIVE.
  - irq_req_o rises one cycle after pending is first sampled.
  - irq_ret_i in IDLE: ignored.
- Winner selection:
  - ROUND_ROBIN=0: lowest set index.
  - ROUND_ROBIN=1: first set index scanning upward from pointer+1, wrapping at N_IRQ-1 -> 0; pointer updated to winner on entry to ACTIVE.
- ACTIVE:
  - irq_req_o=1; irq_id_o and irq_cause_o held stable.
  - Line deassertion or mask change does not withdraw the request.
  - New lines are not re-arbitrated.
  - irq_ret_i=1 at an edge: enter RETURN.
- RETURN (exactly one cycle):
  - irq_req_o=0; irq_ret_o has only bit id set.
  - Next state IDLE unconditionally.
  - irq_id_o/irq_cause_o keep last values until the next grant.
- No back-to-back grant: the IDLE cycle after RETURN samples lines already cleared by the peripheral's return handling. Minimum grant-to-grant spacing: ACTIVE(>=1) + RETURN(1) + IDLE(1).
- Simultaneous lines: exactly one grant; others stay pending in their own peripherals and are served in later rounds.
- irq_ret_i held high across several cycles: only the first edge in ACTIVE counts; extra cycles fall in RETURN/IDLE and are ignored.
- Reset mid-ACTIVE or mid-RETURN: outputs clear immediately (async); any in-flight return pulse is dropped.
- irq_ret_o never has more than one bit set; zero outside RETURN.

Test Plan:
- N_IRQ=4, ROUND_ROBIN=0, mask=4'b1111, lines=4'b0100 at cycle 0 -> irq_req_o=1 from cycle 1, irq_id_o=2, irq_cause_o=32'h8000_0012; pulse irq_ret_i -> next cycle irq_ret_o=4'b0100 for 1 cycle, irq_req_o=0.
- Fixed priority: lines=4'b1010 held, mask=1111 -> first grant id=1; after return with bit1 cleared -> next grant id=3.
- Masking: lines=4'b0001, mask=4'b1110 -> irq_req_o stays 0 for 20 cycles; set mask=1111 -> irq_req_o=1 one cycle later, id=0.
- Round-robin (ROUND_ROBIN=1): lines=4'b1111 held, peripherals not clearing, return each grant -> grant order 0,1,2,3,0.
- Robustness: in ACTIVE (id=2) drop lines to 0 and mask to 0 -> irq_req_o stays 1, id=2 until irq_ret_i; irq_ret_i in IDLE -> irq_ret_o stays 0.
- Reset: assert rst_i low asynchronously during RETURN -> irq_ret_o and irq_req_o go 0 before next edge; after release with lines=0 -> stays IDLE.
